misao_fetch: RTL and testbench
==============================

// Module: misao_fetch
// PURPOSE
//  Instruction fetch unit for the MISA-O core. Reads 8-bit bytes from program memory, splits each
//  into two 4-bit instructions (low nibble first, then high) and buffers them in a small nibble FIFO.
//  Presents one instruction per cycle to the decoder/ALU stage over a valid/ready handshake.
//  Accepts redirects (JAL/JMP/BEQZ/BC/RETI targets) as nibble addresses.
// PARAMETERS
//  DEPTH     4        nibble FIFO entries; power of 2, >= 2
//  RESET_PC  16'h0000 nibble address fetched after reset
//  ADDR_W    15       byte address width (= nibble PC width - 1)
// PORTS
//  clk              input   1       core clock, rising edge
//  rst              input   1       asynchronous, active-low reset
//  mem_enable_read  output  1       byte read request this cycle
//  mem_addr         output  ADDR_W  byte address of request (= fetch_pc[15:1])
//  mem_data_in      input   8       read data, valid the cycle after mem_enable_read
//  mem_stall        input   1       memory owned by data port (XMEM); no fetch issue while high
//  redirect         input   1       load new nibble PC, flush buffer
//  redirect_pc      input   16      target nibble address
//  ins_valid        output  1       ins_nibble/ins_pc hold a valid instruction
//  ins_ready        input   1       decoder consumes head when ins_valid & ins_ready
//  ins_nibble       output  4       instruction/immediate nibble at FIFO head
//  ins_pc           output  16      nibble address of ins_nibble
//  peek_valid       output  1       second FIFO entry valid (see CONFIGURATION)
//  peek_nibble      output  4       second FIFO entry nibble
// BEHAVIOUR
//  - Reset: fetch_pc=RESET_PC, FIFO empty, no pending read, epoch=0; all outputs 0.
//  - Nibble PC n maps to byte n[15:1]; n[0]=0 -> byte[3:0], n[0]=1 -> byte[7:4].
//  - Issue: mem_enable_read=1 iff !mem_stall & !redirect & free slots (after this cycle's pop)
//    >= 2 counting the pending read. Combinational from registers and inputs. One read outstanding max.
//  - Return: cycle t+1 after issue, mem_data_in written at end of t+1 (both nibbles, or only
//    the high nibble if fetch_pc was odd); ins_valid rises at t+2. Pending read carries epoch tag.
//  - fetch_pc advances at issue to the next even nibble (byte + 1). 16-bit wrap: 0xFFFF -> 0x0000,
//    byte 0x7FFF -> 0x0000.
//  - Redirect (cycle N): FIFO flushed, epoch toggled, fetch_pc=redirect_pc at end of N; a read
//    returning in N+1 with stale epoch is discarded. New read issued N+1, ins_valid at N+3.
//    Odd target: low nibble dropped. Redirect wins over same-cycle pop (pop ignored).
//  - Simultaneous push+pop: both happen; count unchanged if one pushed, +1 if two pushed.
//  - Full: no issue; ins_nibble/ins_pc held stable while ins_valid & !ins_ready.
//  - Empty: ins_valid=0; ins_nibble/ins_pc don't-care (drive 0).
//  - rst low mid-read: returning data discarded; state returns to reset values immediately.
//  - States (fetch_state_t): IDLE (reset, no request), RUN (issuing/buffer not full),
//    HOLD (full or mem_stall). IDLE->RUN first cycle out of reset; RUN<->HOLD on occupancy/stall;
//    any -> RUN on redirect.
// CONFIGURATION
//  MISAO_FETCH_PEEK_EN defined: peek_valid/peek_nibble show the entry behind the head (for
//    LDI #imm4 and other two-nibble ops); issue needs >=2 entries valid to assert peek_valid.
//  Undefined: peek_valid=0, peek_nibble=0 constant; second-entry read logic removed.
// STRUCTURE
//  misao_pkg: opcode nibble localparams (base + XOP-extended), fetch_state_t enum,
//    fetch_entry_t struct {nibble[3:0], pc[15:0]}.
//  Sub-module misao_nib_fifo: DEPTH-entry fetch_entry_t FIFO, 0/1/2-write + 1-read per cycle,
//    flush, count output; misao_fetch holds PC, epoch, issue FSM.
// TESTING
//  1 mem[0]=8'h18, mem[1]=8'h0C, ins_ready=1 -> nibbles 8,1,C,0 at pc 0,1,2,3; first ins_valid
//    3rd cycle after rst release.
//  2 ins_ready=0 for 10 cycles -> mem_enable_read stops with 4 entries held; release -> no loss,
//    no duplicate, pc contiguous.
//  3 redirect_pc=16'h0005 while read in flight -> stale data dropped; next ins is mem[2][7:4] at
//    pc 5, valid at N+3.
//  4 mem_stall=1 for 5 cycles with empty FIFO -> mem_enable_read=0, ins_valid=0; resume fetches
//    from same pc.
//  5 RESET_PC=16'hFFFF -> first ins mem[0x7FFF][7:4] pc FFFF, then mem[0][3:0] pc 0000.
//  6 rst low during pending read -> all outputs 0; after release fetch restarts at RESET_PC;
//    with MISAO_FETCH_PEEK_EN, case 1 shows peek_nibble=1 while head=8.

Source files
------------

// File: rtl/misao_pkg.sv
// Shared types for the MISA-O fetch path: opcode nibbles, fetch FSM states, buffered entry layout.
package misao_pkg;

   localparam int NIB_W = 4;
   localparam int PC_W  = 16;

   // Base opcode nibbles, with XOP-extended ops that follow an XOP prefix nibble
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_LDI  = 4'h5;
   localparam logic [3:0] OP_BEQZ = 4'h6;
   localparam logic [3:0] OP_JAL  = 4'h7;
   localparam logic [3:0] OP_XOP  = 4'hF;
   localparam logic [3:0] XOP_JMP  = 4'h0;
   localparam logic [3:0] XOP_BC   = 4'h1;
   localparam logic [3:0] XOP_RETI = 4'h2;
   localparam logic [3:0] XOP_XMEM = 4'h3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [3:0]  nibble;
      logic [15:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/misao_nib_fifo.sv
// Nibble FIFO for the fetch unit: up to two writes and one read per cycle, with flush.
// MISAO_FETCH_PEEK_EN exposes the entry behind the head.
module misao_nib_fifo
   import misao_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [1:0]               push_n,
   input  fetch_entry_t             wr_lo,
   input  fetch_entry_t             wr_hi,
   input  logic                     pop,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     peek_valid,
   output logic [3:0]               peek_nibble
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   fetch_entry_t  mem [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_n);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push_n) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push_n != 2'd0)
            mem[wr_ptr] <= wr_lo;
         if (push_n == 2'd2)
            mem[wr_ptr + 1'b1] <= wr_hi;
      end
   end

   assign head = mem[rd_ptr];

`ifdef MISAO_FETCH_PEEK_EN
   assign peek_valid  = (count >= CW'(2));
   assign peek_nibble = peek_valid ? mem[rd_ptr + 1'b1].nibble : 4'h0;
`else
   assign peek_valid  = 1'b0;
   assign peek_nibble = 4'h0;
`endif

endmodule

// File: rtl/misao_fetch.sv
// MISA-O instruction fetch: byte reads split into nibbles, buffered, handed out over valid/ready.
// Optional MISAO_FETCH_PEEK_EN shows the second buffered nibble on peek_valid/peek_nibble.
module misao_fetch
   import misao_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          ADDR_W   = 15
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_enable_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_data_in,
   input  logic              mem_stall,
   input  logic              redirect,
   input  logic [15:0]       redirect_pc,
   output logic              ins_valid,
   input  logic              ins_ready,
   output logic [3:0]        ins_nibble,
   output logic [15:0]       ins_pc,
   output logic              peek_valid,
   output logic [3:0]        peek_nibble
);

   fetch_state_t          state;
   fetch_state_t          state_nxt;
   logic [15:0]           fetch_pc;
   logic                  epoch;
   logic                  pend_valid;
   logic                  pend_epoch;
   logic                  pend_odd;
   logic [14:0]           pend_byte;
   logic                  pop;
   logic                  ret_ok;
   logic                  issue;
   logic [1:0]            push_n;
   fetch_entry_t          wr_lo;
   fetch_entry_t          wr_hi;
   fetch_entry_t          head;
   logic [$clog2(DEPTH):0] count;
   int                    occ_next;

   // A read only issues if the buffer can absorb a full byte after this cycle's push and pop,
   // so the single outstanding return can never overflow it
   always_comb begin
      pop    = ins_valid & ins_ready & ~redirect;
      ret_ok = pend_valid & (pend_epoch == epoch) & ~redirect;
      push_n = 2'd0;
      if (ret_ok)
         push_n = pend_odd ? 2'd1 : 2'd2;
      wr_hi = '{nibble: mem_data_in[7:4], pc: {pend_byte, 1'b1}};
      wr_lo = pend_odd ? wr_hi : '{nibble: mem_data_in[3:0], pc: {pend_byte, 1'b0}};
      occ_next = int'(count) + int'(push_n) - int'(pop);
      issue = (state != IDLE) & ~mem_stall & ~redirect & ((DEPTH - occ_next) >= 2);
      if (redirect || state == IDLE)
         state_nxt = RUN;
      else if (mem_stall || occ_next == DEPTH)
         state_nxt = HOLD;
      else
         state_nxt = RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         epoch      <= 1'b0;
         pend_valid <= 1'b0;
         pend_epoch <= 1'b0;
         pend_odd   <= 1'b0;
         pend_byte  <= '0;
      end else begin
         state      <= state_nxt;
         pend_valid <= issue;
         if (issue) begin
            pend_epoch <= epoch;
            pend_odd   <= fetch_pc[0];
            pend_byte  <= fetch_pc[15:1];
         end
         if (redirect) begin
            fetch_pc <= redirect_pc;
            epoch    <= ~epoch;
         end else if (issue) begin
            fetch_pc <= {fetch_pc[15:1] + 15'd1, 1'b0};
         end
      end
   end

   misao_nib_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush       (redirect),
      .push_n      (push_n),
      .wr_lo       (wr_lo),
      .wr_hi       (wr_hi),
      .pop         (pop),
      .head        (head),
      .count       (count),
      .peek_valid  (peek_valid),
      .peek_nibble (peek_nibble)
   );

   assign mem_enable_read = issue;
   assign mem_addr        = issue ? fetch_pc[ADDR_W:1] : '0;
   assign ins_valid       = (count != '0);
   assign ins_nibble      = ins_valid ? head.nibble : 4'h0;
   assign ins_pc          = ins_valid ? head.pc : 16'h0000;

endmodule

// File: tb/tb_misao_fetch.sv
// Bench for misao_fetch: directed timing steps plus randomized traffic against an
// in-order instruction-stream model over a byte memory.
module tb_misao_fetch;

   logic        clk;
   logic        rst;
   logic        mem_enable_read;
   logic [14:0] mem_addr;
   logic [7:0]  mem_data_in;
   logic        mem_stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        ins_valid;
   logic        ins_ready;
   logic [3:0]  ins_nibble;
   logic [15:0] ins_pc;
   logic        peek_valid;
   logic [3:0]  peek_nibble;

   logic [7:0]  mem [0:32767];
   int          checks;
   int          errors;
   logic [15:0] exp_pc;

   logic        s_en;
   logic [14:0] s_addr;
   logic        s_valid;
   logic [3:0]  s_nib;
   logic [15:0] s_pc;
   logic        s_pv;
   logic [3:0]  s_pn;
   logic [15:0] held_pc;

   misao_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .mem_enable_read (mem_enable_read),
      .mem_addr        (mem_addr),
      .mem_data_in     (mem_data_in),
      .mem_stall       (mem_stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .ins_valid       (ins_valid),
      .ins_ready       (ins_ready),
      .ins_nibble      (ins_nibble),
      .ins_pc          (ins_pc),
      .peek_valid      (peek_valid),
      .peek_nibble     (peek_nibble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous program memory: data the cycle after a request, junk otherwise
   always @(posedge clk) begin
      if (mem_enable_read)
         mem_data_in <= mem[mem_addr];
      else
         mem_data_in <= 8'($urandom);
   end

   function automatic logic [3:0] nib(input logic [15:0] p);
      logic [7:0] b;
      b = mem[p[15:1]];
      return p[0] ? b[7:4] : b[3:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock cycle: sample just after inputs settle, check the stream, then advance the model
   task automatic applyStimulus();
      #1;
      s_en    = mem_enable_read;
      s_addr  = mem_addr;
      s_valid = ins_valid;
      s_nib   = ins_nibble;
      s_pc    = ins_pc;
      s_pv    = peek_valid;
      s_pn    = peek_nibble;
      if (s_valid) begin
         checkOutput("stream_pc", s_pc, exp_pc);
         checkOutput("stream_nib", s_nib, nib(exp_pc));
      end
`ifdef MISAO_FETCH_PEEK_EN
      if (s_pv)
         checkOutput("peek_nib", s_pn, nib(exp_pc + 16'd1));
`else
      checkOutput("peek_off", {s_pv, s_pn}, 5'd0);
`endif
      if (mem_stall || redirect)
         checkOutput("no_issue", s_en, 1'b0);
      @(posedge clk);
      if (!rst)
         exp_pc = 16'h0000;
      else if (redirect)
         exp_pc = redirect_pc;
      else if (s_valid && ins_ready)
         exp_pc = exp_pc + 16'd1;
      @(negedge clk);
   endtask

   task automatic waitIssue(input string tag);
      int n;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (!s_en && n < 20);
      checkOutput(tag, s_en, 1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 32768; i++)
         mem[i] = 8'($urandom);
      mem[0] = 8'h18;
      mem[1] = 8'h0C;
      rst         = 1'b0;
      ins_ready   = 1'b1;
      mem_stall   = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      exp_pc      = 16'h0000;
      repeat (2) @(negedge clk);

      // Reset state
      applyStimulus();
      checkOutput("rst_en", s_en, 1'b0);
      checkOutput("rst_addr", s_addr, 15'd0);
      checkOutput("rst_valid", s_valid, 1'b0);
      checkOutput("rst_head", {s_nib, s_pc}, 20'd0);
      checkOutput("rst_peek", {s_pv, s_pn}, 5'd0);

      // Case 1: first fetch and nibble order
      rst = 1'b1;
      applyStimulus();
      checkOutput("c1_cyc0", {s_en, s_valid}, 2'b00);
      applyStimulus();
      checkOutput("c1_issue", {s_en, s_valid}, 2'b10);
      checkOutput("c1_addr", s_addr, 15'd0);
      applyStimulus();
      checkOutput("c1_cyc2_valid", s_valid, 1'b0);
      applyStimulus();
      checkOutput("c1_first", {s_valid, s_nib, s_pc}, {1'b1, 4'h8, 16'h0000});
`ifdef MISAO_FETCH_PEEK_EN
      checkOutput("c1_peek", {s_pv, s_pn}, {1'b1, 4'h1});
`endif
      applyStimulus();
      checkOutput("c1_second", {s_valid, s_nib, s_pc}, {1'b1, 4'h1, 16'h0001});
      applyStimulus();
      checkOutput("c1_third", {s_valid, s_nib, s_pc}, {1'b1, 4'hC, 16'h0002});
      applyStimulus();
      checkOutput("c1_fourth", {s_valid, s_nib, s_pc}, {1'b1, 4'h0, 16'h0003});

      // Case 2: backpressure fills the buffer and holds the head
      ins_ready = 1'b0;
      applyStimulus();
      held_pc = s_pc;
      checkOutput("c2_valid", s_valid, 1'b1);
      repeat (9) applyStimulus();
      checkOutput("c2_full_no_issue", s_en, 1'b0);
      checkOutput("c2_held", {s_valid, s_pc}, {1'b1, held_pc});
      ins_ready = 1'b1;
      repeat (12) applyStimulus();

      // Case 3: redirect with a read in flight
      waitIssue("c3_wait_issue");
      redirect    = 1'b1;
      redirect_pc = 16'h0005;
      applyStimulus();
      checkOutput("c3_redir_en", s_en, 1'b0);
      redirect = 1'b0;
      applyStimulus();
      checkOutput("c3_n1", {s_valid, s_en, s_addr}, {1'b1 ^ 1'b1, 1'b1, 15'd2});
      applyStimulus();
      checkOutput("c3_n2_valid", s_valid, 1'b0);
      applyStimulus();
      checkOutput("c3_n3", {s_valid, s_nib, s_pc}, {1'b1, mem[2][7:4], 16'h0005});
      repeat (6) applyStimulus();

      // Case 4: memory stall drains the buffer, then fetch resumes in place
      mem_stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus();
         if (i >= 5)
            checkOutput("c4_empty", s_valid, 1'b0);
      end
      mem_stall = 1'b0;
      applyStimulus();
      checkOutput("c4_resume", {s_en, s_addr}, {1'b1, exp_pc[15:1]});
      repeat (8) applyStimulus();

      // Case 5: wrap from the top of the nibble space
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      applyStimulus();
      redirect = 1'b0;
      applyStimulus();
      checkOutput("c5_addr_top", {s_en, s_addr}, {1'b1, 15'h7FFF});
      applyStimulus();
      checkOutput("c5_addr_wrap", {s_en, s_addr}, {1'b1, 15'h0000});
      applyStimulus();
      checkOutput("c5_top", {s_valid, s_nib, s_pc}, {1'b1, mem[15'h7FFF][7:4], 16'hFFFF});
      applyStimulus();
      checkOutput("c5_wrap", {s_valid, s_nib, s_pc}, {1'b1, 4'h8, 16'h0000});

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         ins_ready   = ($urandom_range(0, 3) != 0);
         mem_stall   = ($urandom_range(0, 7) == 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = 16'($urandom);
         applyStimulus();
      end
      ins_ready = 1'b1;
      mem_stall = 1'b0;
      redirect  = 1'b0;
      repeat (10) applyStimulus();

      // Case 6: reset during a pending read
      waitIssue("c6_wait_issue");
      rst = 1'b0;
      applyStimulus();
      checkOutput("c6_outputs", {s_en, s_addr, s_valid, s_nib, s_pc, s_pv, s_pn},
                  {1'b0, 15'd0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0});
      applyStimulus();
      rst = 1'b1;
      repeat (3) applyStimulus();
      applyStimulus();
      checkOutput("c6_restart", {s_valid, s_nib, s_pc}, {1'b1, 4'h8, 16'h0000});
      repeat (4) applyStimulus();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
